pfpu_i2f_arb: RTL and testbench
===============================

Name: pfpu_i2f_arb

Overview:
- Shared signed-integer to IEEE-754 single-precision converter for the PFPU.
- Round-robin arbitration among NREQ requesters; one pipelined normalisation datapath (leading-zero count, left shift, exponent build).
- Two-stage pipeline: one conversion per cycle; valid/ready back-pressure on the output.
- Results are tagged with the requester index so the caller can route them back.

Parameters:
- NREQ, 4, number of requesters (2..4).
- IDW, 2, width of requester ID; NREQ <= 2^IDW.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  requester i has an operand pending.
- req_data  in  32*NREQ  signed operand; requester i at [32i+31:32i].
- req_ack  out  NREQ  one-hot; operand of requester i captured at this clock edge.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_id  out  IDW  requester index of the result.
- out_float  out  32  IEEE-754 single result.
- busy  out  1  any pipeline stage occupied.

Behaviour:
- Reset (async, sys_rst_n low): s1_valid = s2_valid = 0; out_valid = 0; out_id = 0; out_float = 0; rr pointer = 0; req_ack = 0.
- Stall: stall = out_valid & ~out_ready.
  - S2 advances when ~stall.
  - S1 advances when S2 advances or S2 is empty.
  - S1 accepts when S1 is empty or S1 advances.
- Arbitration:
  - req_ack is combinational. It is high only when S1 accepts.
  - Grant goes to the first asserted req_valid searching from pointer upward, modulo NREQ.
  - On grant to i, pointer becomes (i+1) mod NREQ; otherwise the pointer holds.
  - A requester holds req_valid and data stable until acked. Deasserting without ack is permitted and loses nothing.
- S1 registers the granted id, sign = d[31], and mag = |d| as unsigned 32-bit (0x80000000 stays 0x80000000).
- S2 combinational normalise:
  - lz = leading zeros of mag (0..31).
  - sh = mag << lz.
  - exp = 158 - lz (8-bit).
  - frac = sh[30:8], truncated toward zero, no rounding.
  - mag == 0 forces the result to 0x00000000 (sign cleared). Zero must be detected explicitly; lz alone is not sufficient.
  - Result = {sign, exp, frac}; it is registered into out_float/out_id/out_valid.
- Latency: ack in cycle k -> out_valid high in cycle k+2 if no stall. Throughput is 1/cycle.
- While stalled: out_float/out_id hold. No req_ack when both stages are full. Nothing is dropped or duplicated.
- Handshake completes on the rising edge with out_valid & out_ready. Back-to-back results are allowed.
- busy = s1_valid | s2_valid.
- Reset mid-operation discards in-flight operands; unacked requesters simply re-present after reset.

Decomposition:
- Shared PFPU package constants:
  - I2F_EXP_BASE = 158 (bias 127 + 31).
  - FLOAT_ZERO = 32'h00000000.
- Sub-module pfpu_i2f_norm: purely combinational.
  - Inputs: 32-bit magnitude and sign.
  - Outputs: packed float, including the zero special case.
  - Leading-zero count via a divide-and-conquer halving tree.
- Arbiter, pipeline registers and stall logic stay in the top.

Test Plan:
- Single req on port 0, data 32'd1 -> ack one cycle, out_valid two cycles later, out_float 0x3F800000, out_id 0.
- Corner operands on port 2 -> expected results:
  - 0 -> 0x00000000
  - -1 -> 0xBF800000
  - 0x80000000 -> 0xCF000000
  - 0x7FFFFFFF -> 0x4EFFFFFF
  - 16777217 -> 0x4B800000 (truncation)
- All four req_valid held high, out_ready=1 -> acks 0,1,2,3,0,1; out_id follows the same order one result per cycle; no gaps.
- Pointer at 2, req_valid = 4'b1010 -> grant 3 first, then 1. Deassert req 1 before its ack -> no result for id 1.
- Pipeline full, out_ready low 3 cycles -> req_ack stays 0; out_float/out_id stable; after release, all pending results emerge in order without loss.
- Assert sys_rst_n low with both stages full -> out_valid, busy and req_ack drop immediately. After release, the first grant goes to port 0.

Source files
------------

// File: rtl/pfpu_i2f_arb_pkg.sv
// Shared PFPU constants and types for the integer-to-float converter.
// Pure declarations; no latency or flow control of its own.
package pfpu_i2f_arb_pkg;

  localparam logic [7:0]  I2F_EXP_BASE = 8'd158;  // bias 127 + 31
  localparam logic [31:0] FLOAT_ZERO   = 32'h00000000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } float_t;

  typedef struct packed {
    logic        sign;
    logic [31:0] mag;
  } i2f_op_t;

  // Two's complement magnitude; 0x80000000 negates to itself, which is the
  // correct unsigned magnitude 2^31.
  function automatic i2f_op_t i2f_split(input logic [31:0] d);
    i2f_op_t op;
    op.sign = d[31];
    op.mag  = d[31] ? (~d + 32'd1) : d;
    return op;
  endfunction

endpackage

// File: rtl/pfpu_i2f_norm.sv
// Combinational normaliser: magnitude + sign -> IEEE-754 single, truncating.
// Zero latency, no flow control; zero input is detected explicitly.
module pfpu_i2f_norm
  import pfpu_i2f_arb_pkg::*;
(
  input  logic [31:0] mag_i,
  input  logic        sign_i,
  output logic [31:0] float_o
);

  logic [4:0]  lz;
  logic [31:0] sh;
  float_t      res;
  logic        unused_sh_bits;

  // Halving tree: each step tests the upper half of what remains and shifts
  // it out if empty, so lz and the normalised value fall out together.
  always_comb begin
    sh = mag_i;
    lz = 5'd0;
    if (sh[31:16] == 16'd0) begin
      lz[4] = 1'b1;
      sh    = {sh[15:0], 16'd0};
    end
    if (sh[31:24] == 8'd0) begin
      lz[3] = 1'b1;
      sh    = {sh[23:0], 8'd0};
    end
    if (sh[31:28] == 4'd0) begin
      lz[2] = 1'b1;
      sh    = {sh[27:0], 4'd0};
    end
    if (sh[31:30] == 2'd0) begin
      lz[1] = 1'b1;
      sh    = {sh[29:0], 2'd0};
    end
    if (sh[31] == 1'b0) begin
      lz[0] = 1'b1;
      sh    = {sh[30:0], 1'b0};
    end
  end

  // Bit 31 is the implicit leading one; bits below 8 are truncated away.
  assign unused_sh_bits = ^{sh[31], sh[7:0]};

  always_comb begin
    res.sign = sign_i;
    res.exp  = I2F_EXP_BASE - {3'b000, lz};
    res.frac = sh[30:8];
    if (mag_i == 32'd0) begin
      float_o = FLOAT_ZERO;
    end else begin
      float_o = res;
    end
  end

endmodule

// File: rtl/pfpu_i2f_arb.sv
// Round-robin shared int->float converter; ack in cycle k gives out_valid in k+2.
// out_ready low holds the result and stalls both stages; no ack when both are full.
module pfpu_i2f_arb
  import pfpu_i2f_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [32*NREQ-1:0]  req_data,
  output logic [NREQ-1:0]     req_ack,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IDW-1:0]      out_id,
  output logic [31:0]         out_float,
  output logic                busy
);

  logic [31:0]    req_word [NREQ];
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           gnt_vld;
  logic [IDW-1:0] gnt_idx;
  logic [31:0]    gnt_dat;

  logic           s1_valid_q, s1_valid_d;
  logic [IDW-1:0] s1_id_q, s1_id_d;
  i2f_op_t        s1_op_q, s1_op_d;

  logic           out_valid_q, out_valid_d;
  logic [IDW-1:0] out_id_q, out_id_d;
  logic [31:0]    out_float_q, out_float_d;
  logic [31:0]    norm_float;

  logic           stall, s2_adv, s1_adv, s1_accept;

  for (genvar g = 0; g < NREQ; g++) begin : g_word
    assign req_word[g] = req_data[32*g +: 32];
  end

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    return IDW'(sum);
  endfunction

  assign stall     = out_valid_q & ~out_ready;
  assign s2_adv    = ~stall;
  assign s1_adv    = s2_adv | ~out_valid_q;
  assign s1_accept = ~s1_valid_q | s1_adv;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_vld && req_valid[rr_idx(ptr_q, k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = rr_idx(ptr_q, k);
      end
    end
  end

  assign gnt_dat = req_word[gnt_idx];

  // Gated by reset so a requester never sees an ack that no register captures.
  always_comb begin
    req_ack = '0;
    if (gnt_vld && s1_accept && sys_rst_n) begin
      req_ack = {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx;
    end
  end

  always_comb begin
    ptr_d      = ptr_q;
    s1_valid_d = s1_valid_q;
    s1_id_d    = s1_id_q;
    s1_op_d    = s1_op_q;
    if (s1_accept) begin
      s1_valid_d = gnt_vld;
      if (gnt_vld) begin
        s1_id_d = gnt_idx;
        s1_op_d = i2f_split(gnt_dat);
        ptr_d   = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  pfpu_i2f_norm u_norm (
    .mag_i   (s1_op_q.mag),
    .sign_i  (s1_op_q.sign),
    .float_o (norm_float)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_float_d = out_float_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_id_d    = s1_id_q;
        out_float_d = norm_float;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      s1_op_q     <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_float_q <= FLOAT_ZERO;
    end else begin
      ptr_q       <= ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_id_q     <= s1_id_d;
      s1_op_q     <= s1_op_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_float_q <= out_float_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_float = out_float_q;
  assign busy      = s1_valid_q | out_valid_q;

endmodule

// File: tb/tb_pfpu_i2f_arb.sv
// Directed bench for pfpu_i2f_arb: per-scenario tasks with hand-computed results.
module tb_pfpu_i2f_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                sys_clk = 1'b0;
  logic                sys_rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [32*NREQ-1:0]  req_data;
  logic [NREQ-1:0]     req_ack;
  logic                out_valid;
  logic                out_ready;
  logic [IDW-1:0]      out_id;
  logic [31:0]         out_float;
  logic                busy;

  int checks   = 0;
  int failures = 0;

  logic [31:0]     pq [NREQ][$];
  logic            rdy_sched[$];
  int              ack_log[$];
  int              ack_cyc[$];
  int              res_cyc[$];
  logic [IDW-1:0]  res_id[$];
  logic [31:0]     res_f[$];
  logic [NREQ-1:0] snap_ack[$];
  logic            snap_ov[$];
  logic            snap_busy[$];
  logic [31:0]     snap_f[$];
  logic [IDW-1:0]  snap_id[$];

  pfpu_i2f_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .out_float (out_float),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [31:0] rf(input int i);
    if (i < res_f.size()) return res_f[i];
    return 'x;
  endfunction

  function automatic logic [IDW-1:0] rid(input int i);
    if (i < res_id.size()) return res_id[i];
    return 'x;
  endfunction

  function automatic int rcyc(input int i);
    if (i < res_cyc.size()) return res_cyc[i];
    return -99;
  endfunction

  function automatic int aport(input int i);
    if (i < ack_log.size()) return ack_log[i];
    return -99;
  endfunction

  function automatic int acyc(input int i);
    if (i < ack_cyc.size()) return ack_cyc[i];
    return -99;
  endfunction

  task automatic drive(input int c);
    for (int p = 0; p < NREQ; p++) begin
      req_valid[p] = (pq[p].size() > 0);
      if (pq[p].size() > 0) req_data[32*p +: 32] = pq[p][0];
      else                  req_data[32*p +: 32] = 32'h0;
    end
    if (c < rdy_sched.size()) out_ready = rdy_sched[c];
    else                      out_ready = 1'b1;
  endtask

  // Runs n cycles from just after a rising edge, feeding the per-port queues
  // and logging acks, handshakes and per-cycle output snapshots.
  task automatic run_cycles(input int n);
    logic [NREQ-1:0] a;
    ack_log.delete(); ack_cyc.delete(); res_cyc.delete(); res_id.delete(); res_f.delete();
    snap_ack.delete(); snap_ov.delete(); snap_busy.delete(); snap_f.delete(); snap_id.delete();
    for (int c = 0; c < n; c++) begin
      drive(c);
      @(negedge sys_clk);
      a = req_ack;
      snap_ack.push_back(a);
      snap_ov.push_back(out_valid);
      snap_busy.push_back(busy);
      snap_f.push_back(out_float);
      snap_id.push_back(out_id);
      if (a != '0) begin
        ack_cyc.push_back(c);
        ack_log.push_back(($countones(a) == 1) ? int'($clog2(a)) : -1);
      end
      if (out_valid && out_ready) begin
        res_id.push_back(out_id);
        res_f.push_back(out_float);
        res_cyc.push_back(c);
      end
      @(posedge sys_clk);
      #1;
      for (int p = 0; p < NREQ; p++) begin
        if (a[p] && pq[p].size() > 0) void'(pq[p].pop_front());
      end
    end
    rdy_sched.delete();
    drive(n);
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0;
    req_valid = '1;
    req_data  = {32'd4, 32'd3, 32'd2, 32'd1};
    out_ready = 1'b1;
    #12;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (req_ack !== 4'b0000) begin failures++; $display("FAIL reset_req_ack got=%b exp=0000", req_ack); end
    checks++; if (out_float !== 32'h0) begin failures++; $display("FAIL reset_out_float got=%h exp=00000000", out_float); end
    checks++; if (out_id !== 2'd0) begin failures++; $display("FAIL reset_out_id got=%0d exp=0", out_id); end
    @(posedge sys_clk);
    #1;
    req_valid = '0;
    sys_rst_n = 1'b1;
  endtask

  task automatic test_single;
    pq[0].push_back(32'd1);
    run_cycles(5);
    checks++; if (aport(0) !== 0 || ack_log.size() != 1) begin failures++; $display("FAIL single_ack port=%0d n=%0d exp port=0 n=1", aport(0), ack_log.size()); end
    checks++; if (acyc(0) != 0) begin failures++; $display("FAIL single_ack_cycle got=%0d exp=0", acyc(0)); end
    checks++; if (snap_ov[1] !== 1'b0 || snap_busy[1] !== 1'b1) begin failures++; $display("FAIL single_c1 ov=%b busy=%b exp ov=0 busy=1", snap_ov[1], snap_busy[1]); end
    checks++; if (rcyc(0) != 2 || res_f.size() != 1) begin failures++; $display("FAIL single_latency cyc=%0d n=%0d exp cyc=2 n=1", rcyc(0), res_f.size()); end
    checks++; if (rf(0) !== 32'h3F800000) begin failures++; $display("FAIL single_float got=%h exp=3f800000", rf(0)); end
    checks++; if (rid(0) !== 2'd0) begin failures++; $display("FAIL single_id got=%0d exp=0", rid(0)); end
    checks++; if (snap_busy[4] !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%b exp=0", snap_busy[4]); end
  endtask

  task automatic test_corners;
    logic [31:0] ops [5];
    logic [31:0] exp_f [5];
    ops   = '{32'h00000000, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd16777217};
    exp_f = '{32'h00000000, 32'hBF800000, 32'hCF000000, 32'h4EFFFFFF, 32'h4B800000};
    for (int i = 0; i < 5; i++) pq[2].push_back(ops[i]);
    run_cycles(9);
    checks++; if (res_f.size() != 5) begin failures++; $display("FAIL corner_count got=%0d exp=5", res_f.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rf(i) !== exp_f[i] || rid(i) !== 2'd2 || rcyc(i) != i + 2) begin
        failures++;
        $display("FAIL corner_%0d float=%h id=%0d cyc=%0d exp float=%h id=2 cyc=%0d", i, rf(i), rid(i), rcyc(i), exp_f[i], i + 2);
      end
    end
  endtask

  task automatic test_sign_port3;
    pq[3].push_back(32'hFFFFFFFA);
    run_cycles(4);
    checks++; if (aport(0) !== 3) begin failures++; $display("FAIL port3_ack got=%0d exp=3", aport(0)); end
    checks++; if (rf(0) !== 32'hC0C00000 || rid(0) !== 2'd3) begin failures++; $display("FAIL port3_result float=%h id=%0d exp float=c0c00000 id=3", rf(0), rid(0)); end
  endtask

  task automatic test_back_to_back;
    int          exp_p [6];
    logic [31:0] exp_f [6];
    exp_p = '{0, 1, 2, 3, 0, 1};
    exp_f = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'hC0000000, 32'h40800000, 32'h41000000};
    pq[0].push_back(32'd1); pq[0].push_back(32'd4);
    pq[1].push_back(32'd2); pq[1].push_back(32'd8);
    pq[2].push_back(32'd3);
    pq[3].push_back(32'hFFFFFFFE);
    run_cycles(10);
    checks++; if (ack_log.size() != 6 || res_f.size() != 6) begin failures++; $display("FAIL b2b_counts acks=%0d res=%0d exp 6 6", ack_log.size(), res_f.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (aport(i) != exp_p[i] || acyc(i) != i) begin
        failures++;
        $display("FAIL b2b_ack_%0d port=%0d cyc=%0d exp port=%0d cyc=%0d", i, aport(i), acyc(i), exp_p[i], i);
      end
      checks++;
      if (rid(i) !== IDW'(exp_p[i]) || rf(i) !== exp_f[i] || rcyc(i) != i + 2) begin
        failures++;
        $display("FAIL b2b_res_%0d id=%0d float=%h cyc=%0d exp id=%0d float=%h cyc=%0d", i, rid(i), rf(i), rcyc(i), exp_p[i], exp_f[i], i + 2);
      end
    end
  endtask

  task automatic test_pointer;
    pq[1].push_back(32'd7);
    pq[3].push_back(32'd9);
    run_cycles(6);
    checks++; if (aport(0) != 3 || aport(1) != 1) begin failures++; $display("FAIL ptr_order got=%0d,%0d exp=3,1", aport(0), aport(1)); end
    checks++; if (rid(0) !== 2'd3 || rf(0) !== 32'h41100000) begin failures++; $display("FAIL ptr_res0 id=%0d float=%h exp id=3 float=41100000", rid(0), rf(0)); end
    checks++; if (rid(1) !== 2'd1 || rf(1) !== 32'h40E00000) begin failures++; $display("FAIL ptr_res1 id=%0d float=%h exp id=1 float=40e00000", rid(1), rf(1)); end
    // Requester 1 withdraws before it is served.
    req_valid = 4'b1010;
    req_data[32*1 +: 32] = 32'd13;
    req_data[32*3 +: 32] = 32'd12;
    @(negedge sys_clk);
    checks++; if (req_ack !== 4'b1000) begin failures++; $display("FAIL withdraw_first_ack got=%b exp=1000", req_ack); end
    @(posedge sys_clk);
    #1;
    req_valid = 4'b0000;
    run_cycles(6);
    checks++; if (ack_log.size() != 0) begin failures++; $display("FAIL withdraw_no_ack got=%0d exp=0", ack_log.size()); end
    checks++; if (res_f.size() != 1 || rid(0) !== 2'd3 || rf(0) !== 32'h41400000 || rcyc(0) != 1) begin
      failures++;
      $display("FAIL withdraw_res n=%0d id=%0d float=%h cyc=%0d exp n=1 id=3 float=41400000 cyc=1", res_f.size(), rid(0), rf(0), rcyc(0));
    end
  endtask

  task automatic test_stall;
    logic [31:0] exp_f [4];
    int          exp_ac [4];
    exp_f  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    exp_ac = '{0, 1, 5, 6};
    for (int i = 1; i <= 4; i++) pq[0].push_back(32'(i));
    for (int i = 0; i < 5; i++) rdy_sched.push_back(1'b0);
    run_cycles(11);
    for (int c = 2; c <= 4; c++) begin
      checks++;
      if (snap_ack[c] !== 4'b0000 || snap_ov[c] !== 1'b1 || snap_f[c] !== 32'h3F800000 || snap_id[c] !== 2'd0) begin
        failures++;
        $display("FAIL stall_hold_c%0d ack=%b ov=%b float=%h id=%0d exp ack=0000 ov=1 float=3f800000 id=0", c, snap_ack[c], snap_ov[c], snap_f[c], snap_id[c]);
      end
    end
    checks++; if (res_f.size() != 4 || ack_log.size() != 4) begin failures++; $display("FAIL stall_counts res=%0d acks=%0d exp 4 4", res_f.size(), ack_log.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rf(i) !== exp_f[i] || rcyc(i) != i + 5 || acyc(i) != exp_ac[i]) begin
        failures++;
        $display("FAIL stall_res_%0d float=%h cyc=%0d ackcyc=%0d exp float=%h cyc=%0d ackcyc=%0d", i, rf(i), rcyc(i), acyc(i), exp_f[i], i + 5, exp_ac[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] exp_f [4];
    exp_f = '{32'h42C80000, 32'h40E00000, 32'h3F800000, 32'hBF800000};
    pq[1].push_back(32'd5); pq[1].push_back(32'd6); pq[1].push_back(32'd7);
    for (int i = 0; i < 6; i++) rdy_sched.push_back(1'b0);
    run_cycles(4);
    out_ready = 1'b0;
    req_valid = 4'b1111;
    #2;
    checks++; if (busy !== 1'b1 || out_valid !== 1'b1 || req_ack !== 4'b0000) begin
      failures++;
      $display("FAIL full_before_reset busy=%b ov=%b ack=%b exp busy=1 ov=1 ack=0000", busy, out_valid, req_ack);
    end
    sys_rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || req_ack !== 4'b0000) begin
      failures++;
      $display("FAIL mid_reset ov=%b busy=%b ack=%b exp ov=0 busy=0 ack=0000", out_valid, busy, req_ack);
    end
    checks++; if (out_float !== 32'h0 || out_id !== 2'd0) begin failures++; $display("FAIL mid_reset_out float=%h id=%0d exp 00000000 0", out_float, out_id); end
    @(posedge sys_clk);
    #1;
    for (int p = 0; p < NREQ; p++) pq[p].delete();
    pq[0].push_back(32'd100);
    pq[1].push_back(32'd7);
    pq[2].push_back(32'd1);
    pq[3].push_back(32'hFFFFFFFF);
    sys_rst_n = 1'b1;
    run_cycles(10);
    checks++; if (aport(0) != 0 || acyc(0) != 0) begin failures++; $display("FAIL post_reset_first_grant port=%0d cyc=%0d exp port=0 cyc=0", aport(0), acyc(0)); end
    checks++; if (res_f.size() != 4) begin failures++; $display("FAIL post_reset_count got=%0d exp=4", res_f.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rid(i) !== IDW'(i) || rf(i) !== exp_f[i]) begin
        failures++;
        $display("FAIL post_reset_res_%0d id=%0d float=%h exp id=%0d float=%h", i, rid(i), rf(i), i, exp_f[i]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_corners();
    test_sign_port3();
    test_back_to_back();
    test_pointer();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
